// File: rtl/carfield_region_pkg.sv
// Shared types and constants for the runtime-programmable Carfield region map.
// Contents: region_t entry type, the reset-time DefaultMap (up to MaxRegions
// entries; unused entries are zero and therefore disabled), config register
// offsets and the commit FSM state encoding.
package carfield_region_pkg;

  localparam int unsigned MaxRegions = 32;

  typedef struct packed {
    logic [63:0] base;
    logic [63:0] size;
    logic        en;
  } region_t;

  typedef region_t [MaxRegions-1:0] region_map_t;

  // Per-region register offsets (region i lives at 0x10*i)
  localparam logic [3:0] OffBaseLo = 4'h0;
  localparam logic [3:0] OffBaseHi = 4'h4;
  localparam logic [3:0] OffSizeLo = 4'h8;
  localparam logic [3:0] OffSizeHi = 4'hC;

  // Global registers
  localparam logic [11:0] AddrEnable = 12'h400;
  localparam logic [11:0] AddrCommit = 12'h404;
  localparam logic [11:0] AddrStatus = 12'h408;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StCheck = 2'd1,
    StApply = 2'd2
  } commit_state_e;

  function automatic region_t mk_region(input logic [63:0] base, input logic [63:0] size);
    region_t r;
    r.base = base;
    r.size = size;
    r.en   = 1'b1;
    return r;
  endfunction

  function automatic region_map_t default_map();
    region_map_t m;
    m    = '0;
    m[0] = mk_region(64'h7800_0000, 64'h0020_0000);  // L2 port 0
    m[1] = mk_region(64'h7820_0000, 64'h0020_0000);  // L2 port 1
    m[2] = mk_region(64'h2000_0000, 64'h0100_0000);  // peripherals
    m[3] = mk_region(64'h4000_0000, 64'h0000_1000);  // mailbox
    m[4] = mk_region(64'h5100_0000, 64'h0080_0000);  // Spatz cluster 0
    m[5] = mk_region(64'h5180_0000, 64'h0080_0000);  // Spatz cluster 1
    return m;
  endfunction

  localparam region_map_t DefaultMap = default_map();

endpackage

// File: rtl/carfield_region_match.sv
// Combinational single-region comparator: hit when en and
// base <= addr < base+size. The offset form avoids computing base+size, so a
// region ending exactly at 2^AddrWidth needs no extra bit. Size 0 never hits.
// Ports: addr, base, size (AddrWidth), en -> hit.
module carfield_region_match #(
  parameter int unsigned AddrWidth = 48
) (
  input  logic [AddrWidth-1:0] addr,
  input  logic [AddrWidth-1:0] base,
  input  logic [AddrWidth-1:0] size,
  input  logic                 en,
  output logic                 hit
);

  logic [AddrWidth-1:0] offset;

  assign offset = addr - base;
  assign hit    = en && (addr >= base) && (offset < size);

endmodule

// File: rtl/carfield_region_map.sv
// Runtime-programmable address-region decoder.
// Config port (cfg_*): shadow base/size/enable registers, COMMIT and STATUS;
//   one-cycle registered response, writes stall while a commit is in flight.
// Lookup port (lkp_* / rsp_*): one registered stage with valid/ready, decodes
//   against the active set, lowest matching index wins.
//
// Commit FSM
//   state   | meaning
//   StIdle  | waiting for a COMMIT write of 1
//   StCheck | one shadow pair (a<b) tested per cycle, row-major
//   StApply | shadow copied to active, commit_err cleared
module carfield_region_map
  import carfield_region_pkg::*;
#(
  parameter int unsigned NumRegions  = 8,
  parameter int unsigned AddrWidth   = 48,
  parameter region_map_t RegDefaults = DefaultMap,
  parameter int unsigned IdxWidth    = $clog2(NumRegions)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cfg_req_i,
  input  logic                 cfg_we_i,
  input  logic [11:0]          cfg_addr_i,
  input  logic [31:0]          cfg_wdata_i,
  output logic                 cfg_gnt_o,
  output logic                 cfg_rvalid_o,
  output logic [31:0]          cfg_rdata_o,
  output logic                 cfg_err_o,
  input  logic                 lkp_valid_i,
  input  logic [AddrWidth-1:0] lkp_addr_i,
  output logic                 lkp_ready_o,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic                 rsp_hit_o,
  output logic [IdxWidth-1:0]  rsp_idx_o
);

  localparam int unsigned NumPairs = NumRegions * (NumRegions - 1) / 2;
  localparam int unsigned PairCntW = $clog2(NumPairs + 1);
  localparam logic [7:0]  NumRegions8 = 8'(NumRegions);

  logic [AddrWidth-1:0]  sh_base  [NumRegions];
  logic [AddrWidth-1:0]  sh_size  [NumRegions];
  logic [NumRegions-1:0] sh_en;
  logic [AddrWidth-1:0]  act_base [NumRegions];
  logic [AddrWidth-1:0]  act_size [NumRegions];
  logic [NumRegions-1:0] act_en;

  commit_state_e         state_q, state_d;
  logic                  busy, scan_en, apply_en;
  logic [IdxWidth-1:0]   pair_a_q, pair_b_q;
  logic [PairCntW-1:0]   pairs_left_q;
  logic                  last_pair, pair_overlap, hit_ab, hit_ba;
  logic                  commit_err_q;
  logic [IdxWidth-1:0]   err_a_q, err_b_q;

  logic                  cfg_wr, region_sel, addr_ok, commit_start;
  logic [IdxWidth-1:0]   reg_idx;
  logic [31:0]           rd_data, status;

  // ---------------- config decode ----------------
  assign cfg_gnt_o    = cfg_req_i & ~(busy & cfg_we_i);
  assign cfg_wr       = cfg_gnt_o & cfg_we_i;
  assign region_sel   = cfg_addr_i[11:4] < NumRegions8;
  assign reg_idx      = cfg_addr_i[4 +: IdxWidth];
  assign commit_start = cfg_wr && (cfg_addr_i == AddrCommit) && cfg_wdata_i[0];
  assign status       = {11'd0, 5'(err_b_q), 3'd0, 5'(err_a_q), 6'd0, commit_err_q, busy};

  always_comb begin
    rd_data = '0;
    addr_ok = 1'b1;
    if (region_sel) begin
      case (cfg_addr_i[3:0])
        OffBaseLo: rd_data = sh_base[reg_idx][31:0];
        OffBaseHi: rd_data = 32'(sh_base[reg_idx] >> 32);
        OffSizeLo: rd_data = sh_size[reg_idx][31:0];
        OffSizeHi: rd_data = 32'(sh_size[reg_idx] >> 32);
        default:   addr_ok = 1'b0;
      endcase
    end else begin
      case (cfg_addr_i)
        AddrEnable: rd_data = 32'(sh_en);
        AddrCommit: rd_data = '0;
        AddrStatus: rd_data = status;
        default:    addr_ok = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NumRegions; i++) begin
        sh_base[i] <= RegDefaults[i].base[AddrWidth-1:0];
        sh_size[i] <= RegDefaults[i].size[AddrWidth-1:0];
        sh_en[i]   <= RegDefaults[i].en;
      end
    end else if (cfg_wr) begin
      if (region_sel) begin
        case (cfg_addr_i[3:0])
          OffBaseLo: sh_base[reg_idx][31:0]           <= cfg_wdata_i;
          OffBaseHi: sh_base[reg_idx][AddrWidth-1:32] <= cfg_wdata_i[AddrWidth-33:0];
          OffSizeLo: sh_size[reg_idx][31:0]           <= cfg_wdata_i;
          OffSizeHi: sh_size[reg_idx][AddrWidth-1:32] <= cfg_wdata_i[AddrWidth-33:0];
          default: ;
        endcase
      end else if (cfg_addr_i == AddrEnable) begin
        sh_en <= cfg_wdata_i[NumRegions-1:0];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cfg_rvalid_o <= 1'b0;
      cfg_rdata_o  <= '0;
      cfg_err_o    <= 1'b0;
    end else begin
      cfg_rvalid_o <= cfg_gnt_o;
      cfg_rdata_o  <= (cfg_gnt_o && !cfg_we_i) ? rd_data : '0;
      cfg_err_o    <= cfg_gnt_o && !addr_ok;
    end
  end

  // ---------------- commit FSM ----------------
  // For non-empty ranges, overlap is equivalent to either base falling inside
  // the other range, which lets the single-region comparator do the test.
  carfield_region_match #(.AddrWidth(AddrWidth)) u_ov_ab (
    .addr(sh_base[pair_a_q]), .base(sh_base[pair_b_q]),
    .size(sh_size[pair_b_q]), .en(sh_en[pair_b_q]), .hit(hit_ab)
  );

  carfield_region_match #(.AddrWidth(AddrWidth)) u_ov_ba (
    .addr(sh_base[pair_b_q]), .base(sh_base[pair_a_q]),
    .size(sh_size[pair_a_q]), .en(sh_en[pair_a_q]), .hit(hit_ba)
  );

  assign pair_overlap = sh_en[pair_a_q] && sh_en[pair_b_q] &&
                        (|sh_size[pair_a_q]) && (|sh_size[pair_b_q]) && (hit_ab || hit_ba);
  assign last_pair    = (pairs_left_q == '0);

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (commit_start) state_d = StCheck;
      StCheck: begin
        if (pair_overlap)   state_d = StIdle;
        else if (last_pair) state_d = StApply;
      end
      StApply: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy     = 1'b0;
    scan_en  = 1'b0;
    apply_en = 1'b0;
    unique case (state_q)
      StCheck: begin busy = 1'b1; scan_en  = 1'b1; end
      StApply: begin busy = 1'b1; apply_en = 1'b1; end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pair_a_q     <= '0;
      pair_b_q     <= '0;
      pairs_left_q <= '0;
      commit_err_q <= 1'b0;
      err_a_q      <= '0;
      err_b_q      <= '0;
    end else begin
      if (commit_start) begin
        pair_a_q     <= '0;
        pair_b_q     <= IdxWidth'(1);
        pairs_left_q <= PairCntW'(NumPairs - 1);
      end else if (scan_en) begin
        if (pair_b_q == IdxWidth'(NumRegions - 1)) begin
          pair_a_q <= pair_a_q + IdxWidth'(1);
          pair_b_q <= pair_a_q + IdxWidth'(2);
        end else begin
          pair_b_q <= pair_b_q + IdxWidth'(1);
        end
        pairs_left_q <= pairs_left_q - PairCntW'(1);
      end
      if (scan_en && pair_overlap) begin
        commit_err_q <= 1'b1;
        err_a_q      <= pair_a_q;
        err_b_q      <= pair_b_q;
      end else if (apply_en) begin
        commit_err_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NumRegions; i++) begin
        act_base[i] <= RegDefaults[i].base[AddrWidth-1:0];
        act_size[i] <= RegDefaults[i].size[AddrWidth-1:0];
        act_en[i]   <= RegDefaults[i].en;
      end
    end else if (apply_en) begin
      act_base <= sh_base;
      act_size <= sh_size;
      act_en   <= sh_en;
    end
  end

  // ---------------- lookup path ----------------
  logic [NumRegions-1:0] lkp_match;
  logic                  lkp_hit;
  logic [IdxWidth-1:0]   lkp_idx;

  for (genvar g = 0; g < NumRegions; g++) begin : gen_match
    carfield_region_match #(.AddrWidth(AddrWidth)) u_match (
      .addr(lkp_addr_i), .base(act_base[g]), .size(act_size[g]),
      .en(act_en[g]), .hit(lkp_match[g])
    );
  end

  // Scan from the top so the lowest matching index is the one left standing.
  always_comb begin
    lkp_hit = 1'b0;
    lkp_idx = '0;
    for (int i = NumRegions - 1; i >= 0; i--) begin
      if (lkp_match[i]) begin
        lkp_hit = 1'b1;
        lkp_idx = IdxWidth'(i);
      end
    end
  end

  assign lkp_ready_o = ~rsp_valid_o | rsp_ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rsp_valid_o <= 1'b0;
      rsp_hit_o   <= 1'b0;
      rsp_idx_o   <= '0;
    end else if (lkp_valid_i && lkp_ready_o) begin
      rsp_valid_o <= 1'b1;
      rsp_hit_o   <= lkp_hit;
      rsp_idx_o   <= lkp_idx;
    end else if (rsp_ready_i) begin
      rsp_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_carfield_region_map.sv
module tb_carfield_region_map;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        cfg_req_i, cfg_we_i;
  logic [11:0] cfg_addr_i;
  logic [31:0] cfg_wdata_i;
  logic        cfg_gnt_o, cfg_rvalid_o, cfg_err_o;
  logic [31:0] cfg_rdata_o;
  logic        lkp_valid_i, lkp_ready_o;
  logic [47:0] lkp_addr_i;
  logic        rsp_valid_o, rsp_ready_i, rsp_hit_o;
  logic [2:0]  rsp_idx_o;

  int pass_cnt = 0;
  int total_cnt = 0;
  logic        bp_en = 1'b0;
  logic [32:0] cfg_q[$];   // {err, rdata}
  logic [3:0]  lkp_q[$];   // {hit, idx}

  always #5 clk = ~clk;

  carfield_region_map dut (
    .clk_i(clk), .rst_i(rst_i),
    .cfg_req_i(cfg_req_i), .cfg_we_i(cfg_we_i), .cfg_addr_i(cfg_addr_i),
    .cfg_wdata_i(cfg_wdata_i), .cfg_gnt_o(cfg_gnt_o), .cfg_rvalid_o(cfg_rvalid_o),
    .cfg_rdata_o(cfg_rdata_o), .cfg_err_o(cfg_err_o),
    .lkp_valid_i(lkp_valid_i), .lkp_addr_i(lkp_addr_i), .lkp_ready_o(lkp_ready_o),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_hit_o(rsp_hit_o), .rsp_idx_o(rsp_idx_o)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
  endtask

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    if (!rst_i && cfg_rvalid_o) begin
      if (cfg_q.size() == 0) check("cfg_unexpected_rvalid", 1, 0);
      else check("cfg_rsp", {cfg_err_o, cfg_rdata_o}, cfg_q.pop_front());
    end
  end

  // Compared on every valid cycle, so a stalled result must keep matching the
  // queue head until it is consumed.
  always @(negedge clk) begin
    if (!rst_i && rsp_valid_o) begin
      if (lkp_q.size() == 0) check("lkp_unexpected_rsp", 1, 0);
      else begin
        check("lkp_rsp", {rsp_hit_o, rsp_idx_o}, lkp_q[0]);
        if (rsp_ready_i) void'(lkp_q.pop_front());
      end
    end
  end

  initial begin
    rsp_ready_i = 1'b1;
    forever begin
      @(posedge clk); #1;
      rsp_ready_i = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    #500us;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // ---------------- drivers ----------------
  task automatic cfg_access(input logic we, input logic [11:0] addr, input logic [31:0] wdata,
                            input logic [31:0] exp_rdata, input logic exp_err);
    int guard = 0;
    @(posedge clk); #1;
    cfg_req_i = 1'b1; cfg_we_i = we; cfg_addr_i = addr; cfg_wdata_i = wdata;
    do begin
      @(negedge clk);
      guard++;
    end while (!cfg_gnt_o && guard < 100);
    if (!cfg_gnt_o) check("cfg_gnt_timeout", 0, 1);
    else cfg_q.push_back({exp_err, we ? 32'd0 : exp_rdata});
    @(posedge clk); #1;
    cfg_req_i = 1'b0; cfg_we_i = 1'b0;
  endtask

  task automatic cfg_wr(input logic [11:0] addr, input logic [31:0] data, input logic exp_err = 1'b0);
    cfg_access(1'b1, addr, data, 32'd0, exp_err);
  endtask

  task automatic cfg_rd(input logic [11:0] addr, input logic [31:0] exp, input logic exp_err = 1'b0);
    cfg_access(1'b0, addr, 32'd0, exp, exp_err);
  endtask

  // Commit, then keep the request line up with a second access and count how
  // many cycles it waits for a grant.
  task automatic commit_follow(input string name, input logic we2, input logic [11:0] addr2,
                               input logic [31:0] wdata2, input logic [31:0] exp_rdata2,
                               input int exp_stall);
    int stall = 0;
    int guard = 0;
    @(posedge clk); #1;
    cfg_req_i = 1'b1; cfg_we_i = 1'b1; cfg_addr_i = 12'h404; cfg_wdata_i = 32'd1;
    do begin
      @(negedge clk);
      guard++;
    end while (!cfg_gnt_o && guard < 100);
    check({name, "_commit_gnt"}, cfg_gnt_o, 1);
    if (cfg_gnt_o) cfg_q.push_back(33'd0);
    @(posedge clk); #1;
    cfg_we_i = we2; cfg_addr_i = addr2; cfg_wdata_i = wdata2;
    forever begin
      @(negedge clk);
      if (cfg_gnt_o || stall >= 100) break;
      stall++;
    end
    check({name, "_stall_cycles"}, stall, exp_stall);
    if (cfg_gnt_o) cfg_q.push_back({1'b0, we2 ? 32'd0 : exp_rdata2});
    @(posedge clk); #1;
    cfg_req_i = 1'b0; cfg_we_i = 1'b0;
  endtask

  // Called at posedge+1; leaves lkp_valid_i high at the next posedge+1.
  task automatic lkp_issue(input logic [47:0] addr, input logic hit, input logic [2:0] idx);
    int guard = 0;
    lkp_valid_i = 1'b1; lkp_addr_i = addr;
    do begin
      @(negedge clk);
      guard++;
    end while (!lkp_ready_o && guard < 100);
    if (!lkp_ready_o) check("lkp_ready_timeout", 0, 1);
    else lkp_q.push_back({hit, idx});
    @(posedge clk); #1;
  endtask

  task automatic lookup(input logic [47:0] addr, input logic hit, input logic [2:0] idx);
    @(posedge clk); #1;
    lkp_issue(addr, hit, idx);
    lkp_valid_i = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    while ((cfg_q.size() != 0 || lkp_q.size() != 0) && guard < 200) begin
      @(posedge clk);
      guard++;
    end
  endtask

  logic [47:0] tbl_addr [8];
  logic [3:0]  tbl_exp  [8];

  initial begin
    tbl_addr[0] = 48'h0000_7800_0010; tbl_exp[0] = {1'b1, 3'd0};
    tbl_addr[1] = 48'h0000_7820_0000; tbl_exp[1] = {1'b1, 3'd1};
    tbl_addr[2] = 48'h0000_781F_FFFF; tbl_exp[2] = {1'b1, 3'd0};
    tbl_addr[3] = 48'h0000_2000_0000; tbl_exp[3] = {1'b1, 3'd2};
    tbl_addr[4] = 48'h0000_4000_0FFF; tbl_exp[4] = {1'b1, 3'd3};
    tbl_addr[5] = 48'h0000_4000_1000; tbl_exp[5] = {1'b0, 3'd0};
    tbl_addr[6] = 48'h0000_5100_0004; tbl_exp[6] = {1'b1, 3'd4};
    tbl_addr[7] = 48'h0000_6000_0FFF; tbl_exp[7] = {1'b1, 3'd7};

    rst_i = 1'b1; cfg_req_i = 1'b0; cfg_we_i = 1'b0; cfg_addr_i = '0; cfg_wdata_i = '0;
    lkp_valid_i = 1'b0; lkp_addr_i = '0;
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;
    @(negedge clk);
    check("rst_rsp_valid", rsp_valid_o, 0);
    check("rst_cfg_rvalid", cfg_rvalid_o, 0);
    check("rst_cfg_err", cfg_err_o, 0);
    check("rst_rsp_hit_idx", {rsp_hit_o, rsp_idx_o}, 0);

    // Defaults after reset
    cfg_rd(12'h408, 32'h0);
    cfg_rd(12'h400, 32'h3F);
    cfg_rd(12'h000, 32'h7800_0000);
    cfg_rd(12'h004, 32'h0);
    cfg_rd(12'h018, 32'h0020_0000);
    cfg_rd(12'h500, 32'h0, 1'b1);
    cfg_rd(12'h080, 32'h0, 1'b1);
    cfg_wr(12'h500, 32'h1234, 1'b1);
    lookup(48'h0000_7800_0010, 1'b1, 3'd0);
    lookup(48'h0000_1000_0000, 1'b0, 3'd0);

    // Program region 7 and commit
    cfg_wr(12'h070, 32'h6000_0000);
    cfg_wr(12'h074, 32'h0);
    cfg_wr(12'h078, 32'h0000_1000);
    cfg_wr(12'h07C, 32'h0);
    cfg_wr(12'h400, 32'hBF);
    cfg_rd(12'h078, 32'h0000_1000);
    lookup(48'h0000_6000_0000, 1'b0, 3'd0);
    commit_follow("commit_ok", 1'b1, 12'h070, 32'h6000_0000, 32'h0, 29);
    lookup(48'h0000_6000_0FFF, 1'b1, 3'd7);
    lookup(48'h0000_6000_1000, 1'b0, 3'd0);
    cfg_rd(12'h408, 32'h0);

    // Region 7 overlapping region 2: first overlap is pair (2,7), 18 cycles in
    cfg_wr(12'h070, 32'h2000_0800);
    commit_follow("commit_ovl", 1'b1, 12'h070, 32'h2000_0800, 32'h0, 18);
    cfg_rd(12'h408, 32'h0007_0202);
    lookup(48'h0000_6000_0800, 1'b1, 3'd7);
    lookup(48'h0000_2000_0800, 1'b1, 3'd2);

    // Reads during CHECK are granted at once and show busy
    commit_follow("check_read", 1'b0, 12'h408, 32'h0, 32'h0007_0203, 0);
    cfg_wr(12'h400, 32'hBF);
    cfg_rd(12'h408, 32'h0007_0202);

    // Back-to-back lookups with random back-pressure
    drain();
    bp_en = 1'b1;
    @(posedge clk); #1;
    for (int n = 0; n < 100; n++) lkp_issue(tbl_addr[n % 8], tbl_exp[n % 8][3], tbl_exp[n % 8][2:0]);
    lkp_valid_i = 1'b0;
    bp_en = 1'b0;
    drain();
    check("stream_all_consumed", 64'(lkp_q.size()), 0);

    // Reset in the middle of CHECK
    cfg_wr(12'h404, 32'h1);
    repeat (5) @(posedge clk);
    #1 rst_i = 1'b1;
    @(posedge clk); #1 rst_i = 1'b0;
    cfg_q.delete();
    lkp_q.delete();
    @(negedge clk);
    check("midrst_rsp_valid", rsp_valid_o, 0);
    check("midrst_gnt_write", {cfg_req_i, cfg_gnt_o}, 0);
    cfg_rd(12'h408, 32'h0);
    cfg_rd(12'h070, 32'h0);
    cfg_rd(12'h400, 32'h3F);
    lookup(48'h0000_6000_0FFF, 1'b0, 3'd0);
    lookup(48'h0000_7800_0010, 1'b1, 3'd0);

    // Region ending exactly at 2^48
    cfg_wr(12'h060, 32'hFFFF_F000);
    cfg_wr(12'h064, 32'h0000_FFFF);
    cfg_wr(12'h068, 32'h0000_1000);
    cfg_wr(12'h06C, 32'h0);
    cfg_wr(12'h400, 32'h7F);
    commit_follow("commit_top", 1'b1, 12'h400, 32'h7F, 32'h0, 29);
    cfg_rd(12'h408, 32'h0);
    lookup(48'hFFFF_FFFF_FFFF, 1'b1, 3'd6);
    lookup(48'hFFFF_FFFF_EFFF, 1'b0, 3'd0);
    lookup(48'hFFFF_FFFF_F000, 1'b1, 3'd6);
    cfg_rd(12'h064, 32'h0000_FFFF);
    cfg_wr(12'h074, 32'hFFFF_FFFF);
    cfg_rd(12'h074, 32'h0000_FFFF);
    cfg_rd(12'h404, 32'h0);

    drain();
    check("cfg_q_empty", 64'(cfg_q.size()), 0);
    check("lkp_q_empty", 64'(lkp_q.size()), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
